// File: rtl/switch_egress_queue_pkg.sv
// Shared definitions for the switch egress path.
//   SW_N_PORTS  : number of switch ports
//   SW_PORT_AW  : port address width
//   SW_DW       : default data word width
//   SW_AW       : default egress storage address width
//   eq_state_e  : egress delivery FSM states
package switch_egress_queue_pkg;

  localparam int SW_N_PORTS = 4;
  localparam int SW_PORT_AW = 2;
  localparam int SW_DW      = 4;
  localparam int SW_AW      = 2;

  typedef enum logic {
    EQ_IDLE    = 1'b0,
    EQ_PRESENT = 1'b1
  } eq_state_e;

endpackage

// File: rtl/switch_fifo_ram.sv
// Egress storage array: 2**AW x DW registers, one synchronous write port,
// one asynchronous read port. No reset; validity is tracked by the owner.
//   clk_i  : clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address
//   rdata  : read data (combinational from raddr)
module switch_fifo_ram
  import switch_egress_queue_pkg::*;
#(
  parameter int DW = SW_DW,
  parameter int AW = SW_AW
) (
  input  logic          clk_i,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk_i) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/switch_egress_queue.sv
// Per-output-port egress buffer. Words from the crossbar write stage are
// stored in a circular buffer and handed one at a time to the attached
// device through an output register with a valid/ack handshake.
//   clk_i   : clock, all logic on posedge
//   rst_i   : synchronous active-high reset
//   fifo_i  : write data from the crossbar data buffer
//   wen     : write strobe for this port
//   full    : storage holds DEPTH words
//   count_o : words in storage (excludes the output register)
//   ovf_o   : sticky, a write was dropped
//   dat_o   : word presented to the device
//   validrx : dat_o is valid
//   ackrx   : device accepts dat_o
//
// FSM
//   state      | meaning
//   EQ_IDLE    | output register empty, validrx=0, ackrx ignored
//   EQ_PRESENT | dat_o holds a word, validrx=1, waiting for ackrx
module switch_egress_queue
  import switch_egress_queue_pkg::*;
#(
  parameter int DW = SW_DW,
  parameter int AW = SW_AW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [DW-1:0] fifo_i,
  input  logic          wen,
  output logic          full,
  output logic [AW:0]   count_o,
  output logic          ovf_o,
  output logic [DW-1:0] dat_o,
  output logic          validrx,
  input  logic          ackrx
);

  localparam int          DEPTH    = 2**AW;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  eq_state_e     state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [DW-1:0] rd_data;
  logic [AW:0]   count_d;
  logic          pop;
  logic          push;

  // The output register is refilled whenever it is empty or being acked.
  assign pop  = (count_o != '0) &&
                ((state == EQ_IDLE) || ((state == EQ_PRESENT) && ackrx));
  // A pop in the same cycle frees a slot, so a write at full is still accepted.
  assign push = wen && ((count_o < CNT_FULL) || pop);
  assign full = (count_o == CNT_FULL);

  always_comb begin
    count_d = count_o;
    if (push && !pop) begin
      count_d = count_o + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_o - CNT_ONE;
    end
  end

  switch_fifo_ram #(
    .DW(DW),
    .AW(AW)
  ) u_ram (
    .clk_i (clk_i),
    .we    (push && !rst_i),
    .waddr (wr_ptr),
    .wdata (fifo_i),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
      ovf_o   <= 1'b0;
      state   <= EQ_IDLE;
      validrx <= 1'b0;
      dat_o   <= '0;
    end else begin
      count_o <= count_d;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (wen && !push) begin
        ovf_o <= 1'b1;
      end
      case (state)
        EQ_IDLE: begin
          if (pop) begin
            state   <= EQ_PRESENT;
            validrx <= 1'b1;
            dat_o   <= rd_data;
          end
        end
        EQ_PRESENT: begin
          if (ackrx) begin
            if (pop) begin
              dat_o <= rd_data;
            end else begin
              // dat_o keeps the last delivered word
              state   <= EQ_IDLE;
              validrx <= 1'b0;
            end
          end
        end
        default: begin
          state   <= EQ_IDLE;
          validrx <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_switch_egress_queue.sv
module tb_switch_egress_queue;

  localparam int DW    = 4;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clk_i  = 1'b0;
  logic          rst_i  = 1'b1;
  logic [DW-1:0] fifo_i = '0;
  logic          wen    = 1'b0;
  logic          ackrx  = 1'b0;
  logic          full;
  logic [AW:0]   count_o;
  logic          ovf_o;
  logic [DW-1:0] dat_o;
  logic          validrx;

  switch_egress_queue #(.DW(DW), .AW(AW)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .fifo_i  (fifo_i),
    .wen     (wen),
    .full    (full),
    .count_o (count_o),
    .ovf_o   (ovf_o),
    .dat_o   (dat_o),
    .validrx (validrx),
    .ackrx   (ackrx)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: storage as a queue, output register as value + flag.
  logic [DW-1:0] m_q[$];
  bit            m_v   = 1'b0;
  logic [DW-1:0] m_d   = '0;
  bit            m_ovf = 1'b0;
  logic [DW-1:0] m_got[$];
  logic [DW-1:0] dut_got[$];

  logic [9:0] dut_vec;
  assign dut_vec = {count_o, full, ovf_o, validrx, dat_o};

  function automatic logic [9:0] exp_vec();
    logic [2:0] c;
    c = 3'(m_q.size());
    return {c, 1'(m_q.size() == DEPTH), 1'(m_ovf), 1'(m_v), m_d};
  endfunction

  task automatic step(input logic r, input logic w, input logic [DW-1:0] d, input logic a);
    bit pop;
    bit push;
    rst_i  = r;
    wen    = w;
    fifo_i = d;
    ackrx  = a;
    if (!r && validrx === 1'b1 && a) dut_got.push_back(dat_o);
    @(posedge clk_i);
    if (r) begin
      m_q.delete();
      m_v   = 1'b0;
      m_d   = '0;
      m_ovf = 1'b0;
    end else begin
      if (m_v && a) m_got.push_back(m_d);
      pop  = (m_q.size() != 0) && (!m_v || a);
      push = w && ((m_q.size() < DEPTH) || pop);
      if (w && !push) m_ovf = 1'b1;
      if (pop) begin
        m_d = m_q.pop_front();
        m_v = 1'b1;
      end else if (m_v && a) begin
        m_v = 1'b0;
      end
      if (push) m_q.push_back(d);
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 4'hA, 1'b0);
      n_checks++;
      if (dut_vec !== 10'h000) begin
        n_fail++;
        $display("FAIL reset_cyc%0d: got %h expected %h", i, dut_vec, 10'h000);
      end
    end
  endtask

  task automatic test_single();
    step(1'b0, 1'b1, 4'h5, 1'b0);
    n_checks++;
    if (dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL single_write: got %h expected %h", dut_vec, exp_vec());
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 4'h0, 1'b0);
      n_checks++;
      if (validrx !== 1'b1 || dat_o !== 4'h5) begin
        n_fail++;
        $display("FAIL single_hold%0d: got valid=%b dat=%h expected valid=1 dat=5", i, validrx, dat_o);
      end
    end
    step(1'b0, 1'b0, 4'h0, 1'b1);
    n_checks++;
    if (validrx !== 1'b0 || dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL single_ack: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_fill_overflow();
    for (int v = 3; v <= 7; v++) begin
      step(1'b0, 1'b1, 4'(v), 1'b0);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL fill_w%0d: got %h expected %h", v, dut_vec, exp_vec());
      end
    end
    n_checks++;
    if (full !== 1'b1 || count_o !== 3'd4 || dat_o !== 4'h3 || validrx !== 1'b1 || ovf_o !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_full: got full=%b count=%0d dat=%h ovf=%b expected 1 4 3 0", full, count_o, dat_o, ovf_o);
    end
    step(1'b0, 1'b1, 4'h8, 1'b0);
    n_checks++;
    if (ovf_o !== 1'b1 || count_o !== 3'd4) begin
      n_fail++;
      $display("FAIL ovf_drop: got ovf=%b count=%0d expected 1 4", ovf_o, count_o);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 4'h0, 1'b0);
      n_checks++;
      if (dut_vec !== exp_vec() || ovf_o !== 1'b1) begin
        n_fail++;
        $display("FAIL ovf_sticky%0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_simul_full();
    logic [DW-1:0] exp_list[$];
    exp_list = '{4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h9};
    dut_got.delete();
    m_got.delete();
    step(1'b0, 1'b1, 4'h9, 1'b1);
    n_checks++;
    if (count_o !== 3'd4 || ovf_o !== 1'b1 || dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL simul_full: got %h expected %h", dut_vec, exp_vec());
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 4'h0, 1'b1);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL simul_drain%0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
    n_checks++;
    if (dut_got.size() != exp_list.size()) begin
      n_fail++;
      $display("FAIL simul_order_len: got %0d expected %0d", dut_got.size(), exp_list.size());
    end else begin
      for (int i = 0; i < exp_list.size(); i++) begin
        n_checks++;
        if (dut_got[i] !== exp_list[i]) begin
          n_fail++;
          $display("FAIL simul_order%0d: got %h expected %h", i, dut_got[i], exp_list[i]);
        end
      end
    end
  endtask

  task automatic test_streaming();
    step(1'b1, 1'b0, 4'h0, 1'b0);
    dut_got.delete();
    m_got.delete();
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 4'(i), 1'b1);
      n_checks++;
      if (dut_vec !== exp_vec() || count_o > 3'd1 || (i >= 1 && validrx !== 1'b1)) begin
        n_fail++;
        $display("FAIL stream%0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 4'h0, 1'b1);
      n_checks++;
      if (dut_vec !== exp_vec() || (i == 0 && validrx !== 1'b1)) begin
        n_fail++;
        $display("FAIL stream_tail%0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
    n_checks++;
    if (dut_got.size() != 12) begin
      n_fail++;
      $display("FAIL stream_len: got %0d expected 12", dut_got.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        n_checks++;
        if (dut_got[i] !== 4'(i)) begin
          n_fail++;
          $display("FAIL stream_order%0d: got %h expected %h", i, dut_got[i], 4'(i));
        end
      end
    end
  endtask

  task automatic test_random();
    int ack_pct;
    step(1'b1, 1'b0, 4'h0, 1'b0);
    dut_got.delete();
    m_got.delete();
    for (int i = 0; i < 400; i++) begin
      ack_pct = (i < 200) ? 25 : 80;
      step(1'b0, 1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 99) < ack_pct));
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL random%0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
    n_checks++;
    if (dut_got.size() != m_got.size()) begin
      n_fail++;
      $display("FAIL random_len: got %0d expected %0d", dut_got.size(), m_got.size());
    end else begin
      for (int i = 0; i < m_got.size(); i++) begin
        n_checks++;
        if (dut_got[i] !== m_got[i]) begin
          n_fail++;
          $display("FAIL random_order%0d: got %h expected %h", i, dut_got[i], m_got[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b0, 4'h0, 1'b0);
    for (int v = 1; v <= 4; v++) step(1'b0, 1'b1, 4'(v), 1'b0);
    step(1'b0, 1'b0, 4'h0, 1'b0);
    n_checks++;
    if (count_o !== 3'd3 || validrx !== 1'b1 || dat_o !== 4'h1) begin
      n_fail++;
      $display("FAIL mid_pre: got count=%0d valid=%b dat=%h expected 3 1 1", count_o, validrx, dat_o);
    end
    step(1'b1, 1'b1, 4'hE, 1'b1);
    n_checks++;
    if (dut_vec !== 10'h000) begin
      n_fail++;
      $display("FAIL mid_reset: got %h expected %h", dut_vec, 10'h000);
    end
    step(1'b0, 1'b1, 4'hC, 1'b0);
    step(1'b0, 1'b0, 4'h0, 1'b0);
    n_checks++;
    if (dat_o !== 4'hC || validrx !== 1'b1 || count_o !== 3'd0 || dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL mid_after: got %h expected dat=C valid=1 count=0 (%h)", dut_vec, exp_vec());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_simul_full();
    test_streaming();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
